adpll_loop_ctrl: RTL and testbench
==================================

ADPLL_LOOP_CTRL -- requirements
Module: adpll_loop_ctrl

Interface
REQ-001 SHALL have parameter DCO_W, default 10, width of the DCO control word.
REQ-002 SHALL have parameter DCO_INIT, default 512, value dco_code takes at reset.
REQ-003 SHALL have parameter COARSE_STEP, default 16, dco_code step size in COARSE.
REQ-004 SHALL have parameter REV_CNT, default 4, direction reversals needed to leave COARSE.
REQ-005 SHALL have parameter LOCK_CNT, default 32, consecutive alternating events needed to declare lock.
REQ-006 SHALL have parameter SLIP_CNT, default 8, same-direction event run that breaks FINE or LOCKED.
REQ-007 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-008 SHALL have port clrn  input  1  reset; asynchronous, active-low.
REQ-009 SHALL have port enable  input  1  loop run enable, synchronous to clk.
REQ-010 SHALL have port up  input  1  PFD up pulse; asynchronous to clk.
REQ-011 SHALL have port down  input  1  PFD down pulse; asynchronous to clk.
REQ-012 SHALL have port dco_code  output  DCO_W  registered DCO control word.
REQ-013 SHALL have port locked  output  1  registered; high only in state LOCKED.
REQ-014 SHALL have port state  output  2  registered; IDLE=0, COARSE=1, FINE=2, LOCKED=3.

Function
REQ-015 SHALL pass up and down each through a 2-flop synchronizer, then a third flop for rising-edge detection, giving 1-cycle pulses up_evt and down_evt.
REQ-016 SHALL treat up_evt and down_evt in the same cycle as no event: no code change, no counter change.
REQ-017 SHALL update dco_code on the clk edge after the event pulse: an up rising edge first sampled at edge N changes dco_code at edge N+3.
REQ-018 SHALL apply up_evt as dco_code += step and down_evt as dco_code -= step.
REQ-019 SHALL use step = COARSE_STEP in COARSE and step = 1 in FINE and LOCKED.
REQ-020 SHALL saturate dco_code: clamp at 2^DCO_W-1 on increment and at 0 on decrement, with no wrap.
REQ-021 SHALL record the direction of the last accepted event (last_dir).
REQ-022 SHALL treat an event opposite to last_dir as a reversal and an event equal to last_dir as a run.
REQ-023 SHALL, in IDLE, hold dco_code, hold all counters at 0, and move to COARSE on the first cycle enable=1.
REQ-024 SHALL, in COARSE, count reversals and move to FINE when the count reaches REV_CNT, clearing all counters.
REQ-025 SHALL, in FINE, increment alt_cnt on each reversal and clear it on each run.
REQ-026 SHALL, in FINE, move to LOCKED when alt_cnt reaches LOCK_CNT.
REQ-027 SHALL, in FINE, track run_cnt (consecutive runs) and move to COARSE when run_cnt reaches SLIP_CNT.
REQ-028 SHALL, in LOCKED, track run_cnt and move to FINE when it reaches SLIP_CNT, with locked dropping on that same edge.
REQ-029 SHALL clear run_cnt on any reversal and clear every counter on every state transition.
REQ-030 SHALL, when enable=0 in any state, go to IDLE on the next edge, with locked=0 and dco_code held.
REQ-031 SHALL, on re-enable, restart in COARSE from the held dco_code.
REQ-032 SHALL ignore the first accepted event after entering COARSE for reversal counting, since last_dir is invalid there, but SHALL still apply it to dco_code.

Reset
REQ-033 SHALL, while clrn=0, force asynchronously dco_code=DCO_INIT, state=IDLE, locked=0, all counters and last_dir valid=0, and all synchronizer flops=0.
REQ-034 SHALL, when clrn asserts mid-operation, take effect immediately regardless of clk and discard pending events.
REQ-035 SHALL leave reset on the first clk edge after clrn deasserts, with no spurious events generated by that release.

Verification
REQ-036 SHALL be verified by: reset release with enable=1 and 3 up pulses -> state 0->1, dco_code 512->528->544->560, each change 3 clk after its pulse.
REQ-037 SHALL be verified by: in COARSE, alternating up/down for 5 events -> state=FINE after the 5th event (4 reversals), then subsequent steps of 1.
REQ-038 SHALL be verified by: in FINE, 32 alternating events -> locked=1, state=3; then 8 consecutive down events -> locked=0, state=2.
REQ-039 SHALL be verified by: dco_code=1015 in COARSE plus 2 up events -> dco_code=1023 and stays 1023, no wrap; mirrored for 0.
REQ-040 SHALL be verified by: up and down pulsed simultaneously -> dco_code and counters unchanged.
REQ-041 SHALL be verified by: enable dropped in LOCKED -> state=IDLE and locked=0 next edge, dco_code held; clrn pulsed low mid-COARSE -> dco_code=512 immediately.

Source files
------------

// File: rtl/adpll_loop_ctrl.sv
// ADPLL loop controller: PFD event sync, saturating DCO code update,
// and IDLE/COARSE/FINE/LOCKED acquisition state machine.
`timescale 1ns/1ps
module adpll_loop_ctrl #(
   parameter int DCO_W       = 10,
   parameter int DCO_INIT    = 512,
   parameter int COARSE_STEP = 16,
   parameter int REV_CNT     = 4,
   parameter int LOCK_CNT    = 32,
   parameter int SLIP_CNT    = 8
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             enable,
   input  logic             up,
   input  logic             down,
   output logic [DCO_W-1:0] dco_code,
   output logic             locked,
   output logic [1:0]       state
);

   localparam int CNT_W = $clog2(LOCK_CNT + REV_CNT + SLIP_CNT + 2);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COARSE = 2'd1,
      FINE   = 2'd2,
      LOCKED = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [DCO_W-1:0] dco_d;
   logic             locked_d;
   logic             last_dir, last_dir_d;
   logic             dir_valid, dir_valid_d;
   logic [CNT_W-1:0] rev_cnt, rev_d;
   logic [CNT_W-1:0] alt_cnt, alt_d;
   logic [CNT_W-1:0] run_cnt, run_d;

   logic [2:0] up_sync, dn_sync;
   logic       up_evt, down_evt;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         up_sync  <= '0;
         dn_sync  <= '0;
         up_evt   <= 1'b0;
         down_evt <= 1'b0;
      end else begin
         up_sync  <= {up_sync[1:0], up};
         dn_sync  <= {dn_sync[1:0], down};
         up_evt   <= up_sync[1] & ~up_sync[2];
         down_evt <= dn_sync[1] & ~dn_sync[2];
      end
   end

   logic             ev, dir, reversal, run;
   logic [DCO_W-1:0] step, dco_up, dco_dn, dco_step;
   logic [DCO_W:0]   sum;

   assign ev       = up_evt ^ down_evt;
   assign dir      = up_evt;
   assign reversal = ev & dir_valid & (dir != last_dir);
   assign run      = ev & dir_valid & (dir == last_dir);

   assign step     = (state_q == COARSE) ? DCO_W'(COARSE_STEP)
                                         : DCO_W'(1);
   assign sum      = {1'b0, dco_code} + {1'b0, step};
   assign dco_up   = sum[DCO_W] ? '1 : sum[DCO_W-1:0];
   assign dco_dn   = (dco_code < step) ? '0 : dco_code - step;
   assign dco_step = dir ? dco_up : dco_dn;

   // A slip is SLIP_CNT same-direction events in a row:
   // the opening event plus SLIP_CNT-1 runs.
   logic slip;
   assign slip = run & (run_cnt == CNT_W'(SLIP_CNT - 2));

   always_comb begin
      state_d     = state_q;
      dco_d       = dco_code;
      last_dir_d  = last_dir;
      dir_valid_d = dir_valid;
      rev_d       = rev_cnt;
      alt_d       = alt_cnt;
      run_d       = run_cnt;
      if (!enable) begin
         state_d     = IDLE;
         dir_valid_d = 1'b0;
         rev_d       = '0;
         alt_d       = '0;
         run_d       = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d     = COARSE;
               dir_valid_d = 1'b0;
               rev_d       = '0;
               alt_d       = '0;
               run_d       = '0;
            end
            COARSE: begin
               if (ev) begin
                  dco_d       = dco_step;
                  last_dir_d  = dir;
                  dir_valid_d = 1'b1;
               end
               if (reversal) begin
                  if (rev_cnt == CNT_W'(REV_CNT - 1)) begin
                     state_d = FINE;
                     rev_d   = '0;
                     alt_d   = '0;
                     run_d   = '0;
                  end else begin
                     rev_d = rev_cnt + 1'b1;
                  end
               end
            end
            FINE: begin
               if (ev) begin
                  dco_d      = dco_step;
                  last_dir_d = dir;
               end
               if (reversal) begin
                  run_d = '0;
                  if (alt_cnt == CNT_W'(LOCK_CNT - 1)) begin
                     state_d = LOCKED;
                     alt_d   = '0;
                     rev_d   = '0;
                  end else begin
                     alt_d = alt_cnt + 1'b1;
                  end
               end else if (run) begin
                  alt_d = '0;
                  if (slip) begin
                     state_d     = COARSE;
                     dir_valid_d = 1'b0;
                     run_d       = '0;
                     rev_d       = '0;
                  end else begin
                     run_d = run_cnt + 1'b1;
                  end
               end
            end
            LOCKED: begin
               if (ev) begin
                  dco_d      = dco_step;
                  last_dir_d = dir;
               end
               if (reversal) begin
                  run_d = '0;
               end else if (run) begin
                  if (slip) begin
                     state_d = FINE;
                     run_d   = '0;
                     alt_d   = '0;
                     rev_d   = '0;
                  end else begin
                     run_d = run_cnt + 1'b1;
                  end
               end
            end
         endcase
      end
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q   <= IDLE;
         dco_code  <= DCO_W'(DCO_INIT);
         locked    <= 1'b0;
         last_dir  <= 1'b0;
         dir_valid <= 1'b0;
         rev_cnt   <= '0;
         alt_cnt   <= '0;
         run_cnt   <= '0;
      end else begin
         state_q   <= state_d;
         dco_code  <= dco_d;
         locked    <= locked_d;
         last_dir  <= last_dir_d;
         dir_valid <= dir_valid_d;
         rev_cnt   <= rev_d;
         alt_cnt   <= alt_d;
         run_cnt   <= run_d;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// Bench for adpll_loop_ctrl: directed acquisition steps plus random
// PFD traffic, checked against an event-level loop model.
`timescale 1ns/1ps
module tb_adpll_loop_ctrl;

   logic       clk = 1'b0;
   logic       clrn;
   logic       enable;
   logic       up;
   logic       down;
   logic [9:0] dco_code;
   logic       locked;
   logic [1:0] state;

   int n_cmp = 0;
   int n_bad = 0;

   adpll_loop_ctrl dut (
      .clk      (clk),
      .clrn     (clrn),
      .enable   (enable),
      .up       (up),
      .down     (down),
      .dco_code (dco_code),
      .locked   (locked),
      .state    (state)
   );

   always #5 clk = ~clk;

   // Model: mode 0..3, dco value, last direction (+1/-1, 0 = none),
   // reversal count, alternation count, same-direction streak length.
   int m_mode, m_dco, m_last, m_rev, m_alt, m_streak;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic m_enter(input int m);
      m_mode   = m;
      m_rev    = 0;
      m_alt    = 0;
      m_streak = 1;
      if (m <= 1) m_last = 0;
   endtask

   task automatic m_event(input int d);
      bit rev, same;
      int stp;
      if (m_mode == 0 || d == 0) return;
      stp   = (m_mode == 1) ? 16 : 1;
      m_dco = m_dco + d * stp;
      if (m_dco > 1023) m_dco = 1023;
      if (m_dco < 0) m_dco = 0;
      rev      = (m_last != 0) && (d != m_last);
      same     = (m_last != 0) && (d == m_last);
      m_last   = d;
      m_streak = same ? m_streak + 1 : 1;
      case (m_mode)
         1: if (rev) begin
            m_rev++;
            if (m_rev == 4) m_enter(2);
         end
         2: begin
            m_alt = rev ? m_alt + 1 : 0;
            if (m_alt == 32) m_enter(3);
            else if (m_streak == 8) m_enter(1);
         end
         3: if (m_streak == 8) m_enter(2);
         default: ;
      endcase
   endtask

   task automatic check_all(input string tag);
      check({tag, "_dco"}, dco_code, m_dco);
      check({tag, "_st"}, state, m_mode);
      check({tag, "_lk"}, locked, (m_mode == 3) ? 1 : 0);
   endtask

   // d: +1 up, -1 down, 0 both at once
   task automatic pulse(input int d, input bit timed, input string tag);
      int old;
      old = m_dco;
      @(negedge clk);
      up   = (d != -1);
      down = (d != 1);
      @(posedge clk);
      @(posedge clk);
      #1;
      up   = 1'b0;
      down = 1'b0;
      @(posedge clk);
      #1;
      if (timed) check({tag, "_n2"}, dco_code, old);
      @(posedge clk);
      #1;
      m_event(d);
      if (timed) check({tag, "_n3"}, dco_code, m_dco);
      repeat (3) @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int d, r;
      clrn   = 1'b1;
      enable = 1'b1;
      up     = 1'b0;
      down   = 1'b0;
      m_dco  = 512;
      m_last = 0;
      m_enter(0);
      #1 clrn = 1'b0;
      #1;
      check("rst_dco", dco_code, 512);
      check("rst_st", state, 0);
      check("rst_lk", locked, 0);

      repeat (3) @(negedge clk);
      clrn = 1'b1;
      #1;
      check("rel_idle", state, 0);
      @(posedge clk);
      #1;
      m_enter(1);
      check("rel_coarse", state, 1);

      for (int i = 0; i < 3; i++) pulse(1, 1'b1, "up3");
      check("up3_560", dco_code, 560);

      for (int i = 0; i < 5; i++)
         pulse((i % 2 == 0) ? 1 : -1, 1'b0, "alt5");
      check("to_fine", state, 2);

      for (int i = 0; i < 32; i++)
         pulse((i % 2 == 0) ? -1 : 1, 1'b0, "alt32");
      check("lock_st", state, 3);
      check("lock_lk", locked, 1);

      for (int i = 0; i < 8; i++) pulse(-1, 1'b0, "slip8");
      check("unlock_st", state, 2);
      check("unlock_lk", locked, 0);

      pulse(0, 1'b0, "both");
      for (int i = 0; i < 6; i++) pulse(-1, 1'b0, "dn6");
      check("no_slip_yet", state, 2);
      pulse(-1, 1'b0, "dn7");
      check("slip_coarse", state, 1);

      for (int i = 0; i < 30; i++) pulse(1, 1'b0, "sat_hi");
      check("sat_1023", dco_code, 1023);
      for (int i = 0; i < 66; i++) pulse(-1, 1'b0, "sat_lo");
      check("sat_0", dco_code, 0);

      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6) d = (m_last == 1) ? -1 : 1;
         else if (r < 9) d = (m_last == 1) ? 1 : -1;
         else d = 0;
         pulse(d, 1'b0, "rnd");
      end

      for (int i = 0; i < 120 && m_mode != 3; i++)
         pulse((m_last == 1) ? -1 : 1, 1'b0, "relock");
      check("relock_lk", locked, 1);

      @(negedge clk);
      enable = 1'b0;
      @(posedge clk);
      #1;
      m_enter(0);
      check("dis_st", state, 0);
      check("dis_lk", locked, 0);
      check("dis_dco", dco_code, m_dco);
      pulse(1, 1'b0, "idle_up");

      @(negedge clk);
      enable = 1'b1;
      @(posedge clk);
      #1;
      m_enter(1);
      check("reen_st", state, 1);
      pulse(1, 1'b1, "reen_up");

      @(negedge clk);
      up = 1'b1;
      @(posedge clk);
      #3 clrn = 1'b0;
      #1;
      check("mid_rst_dco", dco_code, 512);
      check("mid_rst_st", state, 0);
      check("mid_rst_lk", locked, 0);
      up = 1'b0;
      m_dco = 512;
      m_enter(0);
      repeat (2) @(negedge clk);
      clrn = 1'b1;
      @(posedge clk);
      #1;
      m_enter(1);
      check("rst2_st", state, 1);
      repeat (6) @(posedge clk);
      #1;
      check_all("discard");
      pulse(-1, 1'b1, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
